// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the iterative AES decryption datapath.
package aes_dec_pkg;

  localparam int AES_DW     = 128;
  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef logic [AES_DW-1:0] state_t;
  typedef logic [3:0]        round_idx_t;

  typedef enum logic [1:0] {
    LOAD,
    ARMED,
    RUN
  } ark_state_e;

endpackage

// File: rtl/inv_add_round_key_stage_if.sv
// Data-path handshake bundle of the InvAddRoundKey stage: input beat from
// InvSubBytes, registered output beat with its round index.
interface inv_add_round_key_stage_if;
  import aes_dec_pkg::*;

  logic       in_valid;
  logic       in_ready;
  state_t     in_data;
  logic       out_valid;
  logic       out_ready;
  state_t     out_data;
  round_idx_t out_round;
  logic       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_round, out_last
  );

endinterface

// File: rtl/inv_add_round_key_stage_key_store.sv
// Round-key store: NR+1 keys plus a valid mask, one write port, a read port
// indexed by the round counter and a fixed key[NR] read. Build option ARK_ZEROIZE_EN.
module round_key_store
  import aes_dec_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  round_idx_t wr_idx,
  input  state_t     wr_data,
  input  logic       clear,
  input  round_idx_t rd_idx,
  output state_t     rd_key,
  output state_t     init_key,
  output logic       full
);

  state_t      keys [NR+1];
  logic [NR:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (clear) begin
      mask <= '0;
    end else if (wr_en) begin
      mask[wr_idx] <= 1'b1;
    end
  end

  // NOTE: the key array has no reset; the valid mask alone decides whether
  // a key may be used, so resetting 11x128 flops would buy nothing.
  always_ff @(posedge clk) begin
`ifdef ARK_ZEROIZE_EN
    if (clear) begin
      for (int i = 0; i <= NR; i++) keys[i] <= '0;
    end else if (wr_en) begin
      keys[wr_idx] <= wr_data;
    end
`else
    if (wr_en && !clear) begin
      keys[wr_idx] <= wr_data;
    end
`endif
  end

  assign rd_key   = keys[rd_idx];
  assign init_key = keys[NR];
  assign full     = &mask;

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Registered InvAddRoundKey stage: XORs each InvSubBytes result with key[cnt],
// walking cnt from NR-1 down to 0 per block. Optional build macro: ARK_ZEROIZE_EN.
module inv_add_round_key_stage
  import aes_dec_pkg::*;
#(
  parameter int NR = AES_NR_128,
  parameter int DW = AES_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_wr_en,
  input  round_idx_t            key_wr_idx,
  input  logic [DW-1:0]         key_wr_data,
  input  logic                  key_clear,
  output logic                  key_wr_err,
  output logic                  keys_ready,
  output logic [DW-1:0]         init_key,
  inv_add_round_key_stage_if.slave bus
);

  localparam round_idx_t CNT_TOP = round_idx_t'(NR - 1);
  localparam round_idx_t IDX_MAX = round_idx_t'(NR);

  ark_state_e state, state_nxt;
  round_idx_t cnt;
  state_t     rd_key;
  logic       accept;
  logic       wr_ok;
  logic       wr_rej;

  // The store is frozen while a block is in flight so every round of it
  // sees one consistent key schedule.
  assign wr_ok  = key_wr_en && !key_clear && (key_wr_idx <= IDX_MAX) && (state != RUN);
  assign wr_rej = key_wr_en && !key_clear && !wr_ok;

  round_key_store #(.NR(NR)) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_ok),
    .wr_idx   (key_wr_idx),
    .wr_data  (key_wr_data),
    .clear    (key_clear),
    .rd_idx   (cnt),
    .rd_key   (rd_key),
    .init_key (init_key),
    .full     (keys_ready)
  );

  assign bus.in_ready = (state != LOAD) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (keys_ready) state_nxt = ARMED;
      ARMED:   if (accept && cnt != '0) state_nxt = RUN;
      RUN:     if (accept && cnt == '0) state_nxt = ARMED;
      default: state_nxt = LOAD;
    endcase
    if (key_clear) state_nxt = LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_TOP;
    end else if (key_clear) begin
      cnt <= CNT_TOP;
    end else if (accept) begin
      cnt <= (cnt == '0) ? CNT_TOP : cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_wr_err <= 1'b0;
    else     key_wr_err <= wr_rej;
  end

  // A beat accepted in the same cycle as key_clear still uses the old key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_round <= '0;
      bus.out_last  <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data ^ rd_key;
      bus.out_round <= cnt;
      bus.out_last  <= (cnt == '0);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/inv_add_round_key_stage.md
Name: inv_add_round_key_stage

Overview:
Registered InvAddRoundKey stage for the iterative AES decryption datapath. It sits directly downstream of Inverse_subbytes and XORs each 128-bit InvSubBytes result with the round key for the current round. It owns the round-key store, loaded once per key, and sequences round keys NR-1 down to 0 with an internal round counter. It also exports key[NR] for the initial AddRoundKey upstream, and uses a valid/ready handshake on both sides.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); the store holds NR+1 keys.
- DW, 128, state/key width; fixed at 128 and must not be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- key_wr_en  in  1  write one round key
- key_wr_idx  in  4  round-key index, 0..NR
- key_wr_data  in  128  round-key value
- key_clear  in  1  invalidate all stored keys
- key_wr_err  out  1  one-cycle pulse: key write rejected
- keys_ready  out  1  all NR+1 keys valid
- init_key  out  128  key[NR], for the upstream initial AddRoundKey
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept data
- in_data  in  128  InvSubBytes output (sb_out)
- out_valid  out  1  output register valid
- out_ready  in  1  downstream accepts
- out_data  out  128  in_data XOR round key
- out_round  out  4  round index applied to out_data
- out_last  out  1  out_data used key[0], i.e. final plaintext

Behaviour:
- Reset values: out_valid=0, out_data=0, out_round=0, out_last=0, key_wr_err=0, key-valid mask=0, cnt=NR-1, state=LOAD.
- Key store: NR+1 x 128-bit registers plus a valid mask.
  - A write to idx<=NR sets mask[idx].
  - A write to idx>NR is dropped and pulses key_wr_err.
- keys_ready = &mask. init_key = key[NR], combinational from the store.
- FSM states:
  - LOAD: keys incomplete; in_ready=0. When the mask becomes full, go to ARMED.
  - ARMED: keys complete, cnt=NR-1, no block in flight. Key writes are still allowed. First data accept goes to RUN.
  - RUN: mid-block. Key writes are ignored and pulse key_wr_err. An accept with cnt==0 returns to ARMED.
- key_clear, any state:
  - Clears the mask, sets cnt=NR-1, enters LOAD.
  - An already-registered output is still delivered.
  - If key_clear and key_wr_en occur in the same cycle, the clear wins and the write is dropped.
- Handshake:
  - in_ready = (state!=LOAD) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Upstream data must remain stable while in_valid && !in_ready.
- Latency: 1 cycle. On accept, the next edge loads out_data = in_data ^ key[cnt], out_round=cnt, out_last=(cnt==0), out_valid=1.
- Full throughput: simultaneous out_ready and accept replaces the output register without a bubble.
- out_valid clears on out_ready && !accept.
- Counter: decrements on each accept. After 0 it wraps to NR-1 (the next block starts); no other wrap exists.
- The output register holds its value while out_valid && !out_ready.
- Reset mid-block discards the in-flight round and all keys.

Optional Feature:
- ARK_ZEROIZE_EN
  - Defined: key_clear also writes 0 to every key register, in one cycle. Afterwards init_key=0 and readback of every key is 0.
  - Undefined: key_clear clears only the valid mask; key contents persist until overwritten.

Decomposition:
- Shared package aes_dec_pkg:
  - AES_DW=128; AES_NR_128/192/256 = 10/12/14.
  - state_t (128-bit) and round_idx_t (4-bit) typedefs.
  - ark_state_e enum {LOAD, ARMED, RUN}.
- Natural sub-module: round_key_store. It holds the NR+1 keys and mask, with a write port, clear (and zeroize), a read port indexed by cnt, and the fixed key[NR] read.

Test Plan:
- Load keys i=0..10 with {16{8'h0i}} and apply 10 beats of in_data=128'h0 → out_data = {16{8'h09}} down to {16{8'h00}}; out_round 9..0; out_last only on the tenth beat; init_key={16{8'h0A}}.
- Only keys 0..9 loaded, in_valid=1 → in_ready stays 0 and out_valid stays 0. Writing key 10 → keys_ready=1 and the next cycle accepts.
- Hold out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and out_data stable. Then out_ready=1 with in_valid=1 → back-to-back transfer, no bubble.
- Key write (idx 3) during RUN, and a key write with idx=12 → each pulses key_wr_err for 1 cycle; store unchanged.
- Assert key_clear on the 5th beat → state LOAD, cnt=9, pending output delivered. With ARK_ZEROIZE_EN, init_key=0.
- Assert rst mid-block (round 6) → all outputs 0 next sample, keys_ready=0, cnt=9.
